// File: rtl/hazard_stall_controller_pkg.sv
// Shared types for the hazard/stall controller: hazard classes, FSM states,
// statistics-counter indices and the load-stall reload helper.
package hazard_stall_controller_pkg;

    typedef enum logic [1:0] {
        HS_NONE    = 2'b00,
        HS_LOAD    = 2'b01,
        HS_BRANCH  = 2'b10,
        HS_CONTROL = 2'b11
    } hazard_status_e;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_LD_STALL = 1'b1
    } fsm_state_e;

    localparam int NUM_STAT_CNT = 4;
    localparam int CNT_LOAD     = 0;
    localparam int CNT_BRANCH   = 1;
    localparam int CNT_CONTROL  = 2;
    localparam int CNT_STALL    = 3;

    // Down-counter only has to hold LOAD_STALL_CYC-2, at most 1.
    localparam int DCNT_W = 2;

    function automatic logic [DCNT_W-1:0] stall_reload(input int cyc);
        return (cyc > 1) ? DCNT_W'(cyc - 2) : '0;
    endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side bundle of the hazard controller: ID/EX/MEM hazard inputs,
// stall/flush controls and statistics counters.
interface hazard_stall_controller_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    import hazard_stall_controller_pkg::*;

    logic              valid_id;
    logic [REG_AW-1:0] rs_id;
    logic [REG_AW-1:0] rt_id;
    logic              uses_rt_id;
    logic              memread_ex;
    logic              regwrite_ex;
    logic [REG_AW-1:0] rd_ex;
    logic              memread_mem;
    logic [REG_AW-1:0] rd_mem;
    logic              branch_id;
    logic              jump_id;
    logic              branch_taken;
    logic              stat_clr;

    logic              stall_pc;
    logic              stall_ifid;
    logic              bubble_idex;
    logic              flush_ifid;
    hazard_status_e    hazard_status;
    logic [CNT_W-1:0]  load_cnt;
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  control_cnt;
    logic [CNT_W-1:0]  stall_cyc_cnt;

    modport master (
        output valid_id, rs_id, rt_id, uses_rt_id,
        output memread_ex, regwrite_ex, rd_ex, memread_mem, rd_mem,
        output branch_id, jump_id, branch_taken, stat_clr,
        input  stall_pc, stall_ifid, bubble_idex, flush_ifid, hazard_status,
        input  load_cnt, branch_cnt, control_cnt, stall_cyc_cnt
    );

    modport slave (
        input  valid_id, rs_id, rt_id, uses_rt_id,
        input  memread_ex, regwrite_ex, rd_ex, memread_mem, rd_mem,
        input  branch_id, jump_id, branch_taken, stat_clr,
        output stall_pc, stall_ifid, bubble_idex, flush_ifid, hazard_status,
        output load_cnt, branch_cnt, control_cnt, stall_cyc_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Detects load-use, branch-dependency and control hazards for the ID stage,
// drives stall/bubble/flush controls and keeps saturating hazard statistics.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter int CNT_W          = 32,
    parameter int LOAD_STALL_CYC = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    hazard_stall_controller_if.slave  bus
);

    localparam bit                MULTI_CYC   = (LOAD_STALL_CYC > 1);
    localparam logic [DCNT_W-1:0] DCNT_RELOAD = stall_reload(LOAD_STALL_CYC);

    fsm_state_e               state_q;
    fsm_state_e               state_d;
    logic [DCNT_W-1:0]        dcnt_q;
    logic [DCNT_W-1:0]        dcnt_d;

    logic                     src_ex_hit;
    logic                     src_mem_hit;
    logic                     load_use;
    logic                     branch_dep;
    logic                     ctrl;
    logic                     in_run;
    logic                     stall;
    logic                     flush;
    hazard_status_e           status;
    logic [NUM_STAT_CNT-1:0]  cnt_inc;
    logic [CNT_W-1:0]         cnt_val [NUM_STAT_CNT];

    // Register 0 is hardwired, so a producer writing it never creates a dependency.
    function automatic logic src_hit(
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rt,
        input logic              uses_rt
    );
        return (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

    assign src_ex_hit  = bus.valid_id && src_hit(bus.rd_ex,  bus.rs_id, bus.rt_id, bus.uses_rt_id);
    assign src_mem_hit = bus.valid_id && src_hit(bus.rd_mem, bus.rs_id, bus.rt_id, bus.uses_rt_id);

    assign load_use   = bus.memread_ex && src_ex_hit;
    assign branch_dep = bus.valid_id && bus.branch_id &&
                        ((bus.regwrite_ex && src_ex_hit) || (bus.memread_mem && src_mem_hit));
    assign ctrl       = bus.valid_id && (bus.jump_id || (bus.branch_id && bus.branch_taken));

    assign in_run = (state_q == ST_RUN);
    assign stall  = rst_n && ((in_run && (load_use || branch_dep)) || (state_q == ST_LD_STALL));
    assign flush  = rst_n && ctrl && !stall;

    always_comb begin
        status = HS_NONE;
        if (!rst_n) begin
            status = HS_NONE;
        end else if ((state_q == ST_LD_STALL) || (in_run && load_use)) begin
            status = HS_LOAD;
        end else if (in_run && branch_dep) begin
            status = HS_BRANCH;
        end else if (flush) begin
            status = HS_CONTROL;
        end
    end

    // Extra load bubbles beyond the first; a load_use inside LD_STALL is already covered.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_RUN: begin
                if (MULTI_CYC && load_use) begin
                    state_d = ST_LD_STALL;
                    dcnt_d  = DCNT_RELOAD;
                end
            end
            ST_LD_STALL: begin
                if (dcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
                dcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign cnt_inc[CNT_LOAD]    = rst_n && in_run && load_use;
    assign cnt_inc[CNT_BRANCH]  = rst_n && in_run && branch_dep && !load_use;
    assign cnt_inc[CNT_CONTROL] = flush;
    assign cnt_inc[CNT_STALL]   = stall;

    for (genvar gi = 0; gi < NUM_STAT_CNT; gi++) begin : g_stat
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (cnt_inc[gi]),
            .clr_i (bus.stat_clr),
            .cnt_o (cnt_val[gi])
        );
    end

    assign bus.stall_pc      = stall;
    assign bus.stall_ifid    = stall;
    assign bus.bubble_idex   = stall;
    assign bus.flush_ifid    = flush;
    assign bus.hazard_status = status;
    assign bus.load_cnt      = cnt_val[CNT_LOAD];
    assign bus.branch_cnt    = cnt_val[CNT_BRANCH];
    assign bus.control_cnt   = cnt_val[CNT_CONTROL];
    assign bus.stall_cyc_cnt = cnt_val[CNT_STALL];

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: three instances (1/3/2 load bubbles, 3-bit
// counters on the last) share stimulus and are checked against a stall-budget model.
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_id, uses_rt_id, memread_ex, regwrite_ex, memread_mem;
    logic       branch_id, jump_id, branch_taken, stat_clr;
    logic [4:0] rs_id, rt_id, rd_ex, rd_mem;

    logic [5:0]  got_o [3];
    logic [63:0] got_c [3][4];

    int errors = 0;
    int checks = 0;

    localparam int CYC_K [3] = '{1, 3, 2};
    localparam int W_K   [3] = '{32, 32, 3};

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int CYC = (gi == 0) ? 1 : (gi == 1) ? 3 : 2;
        localparam int CW  = (gi == 2) ? 3 : 32;

        hazard_stall_controller_if #(.REG_AW(5), .CNT_W(CW)) bus ();

        assign bus.valid_id     = valid_id;
        assign bus.rs_id        = rs_id;
        assign bus.rt_id        = rt_id;
        assign bus.uses_rt_id   = uses_rt_id;
        assign bus.memread_ex   = memread_ex;
        assign bus.regwrite_ex  = regwrite_ex;
        assign bus.rd_ex        = rd_ex;
        assign bus.memread_mem  = memread_mem;
        assign bus.rd_mem       = rd_mem;
        assign bus.branch_id    = branch_id;
        assign bus.jump_id      = jump_id;
        assign bus.branch_taken = branch_taken;
        assign bus.stat_clr     = stat_clr;

        hazard_stall_controller #(
            .REG_AW         (5),
            .CNT_W          (CW),
            .LOAD_STALL_CYC (CYC)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign got_o[gi]    = {bus.stall_pc, bus.stall_ifid, bus.bubble_idex,
                               bus.flush_ifid, bus.hazard_status};
        assign got_c[gi][0] = 64'(bus.load_cnt);
        assign got_c[gi][1] = 64'(bus.branch_cnt);
        assign got_c[gi][2] = 64'(bus.control_cnt);
        assign got_c[gi][3] = 64'(bus.stall_cyc_cnt);
    end

    // Reference model: remaining bubbles owed per instance plus plain counters.
    int     left [3] = '{0, 0, 0};
    longint mcnt [3][4];

    function automatic bit src(input logic [4:0] rd);
        return (rd != 5'd0) && ((rd == rs_id) || (uses_rt_id && (rd == rt_id)));
    endfunction

    function automatic bit m_lu();
        return valid_id && memread_ex && src(rd_ex);
    endfunction

    function automatic bit m_bd();
        return valid_id && branch_id &&
               ((regwrite_ex && src(rd_ex)) || (memread_mem && src(rd_mem)));
    endfunction

    function automatic bit m_ct();
        return valid_id && (jump_id || (branch_id && branch_taken));
    endfunction

    function automatic bit m_stall(input int k);
        return (left[k] != 0) || m_lu() || m_bd();
    endfunction

    function automatic bit m_flush(input int k);
        return m_ct() && !m_stall(k);
    endfunction

    function automatic logic [5:0] m_outs(input int k);
        logic [1:0] st;
        bit s;
        bit f;
        if (!rst_n) return 6'd0;
        s = m_stall(k);
        f = m_flush(k);
        if ((left[k] != 0) || m_lu()) st = 2'b01;
        else if (m_bd())              st = 2'b10;
        else if (f)                   st = 2'b11;
        else                          st = 2'b00;
        return {s, s, s, f, st};
    endfunction

    function automatic longint bump(input int k, input longint v, input bit inc);
        longint mx;
        mx = (longint'(1) << W_K[k]) - 1;
        if (stat_clr) return 0;
        if (inc && (v < mx)) return v + 1;
        return v;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                left[k] <= 0;
                for (int j = 0; j < 4; j++) mcnt[k][j] <= 0;
            end else begin
                if (left[k] != 0) left[k] <= left[k] - 1;
                else if (m_lu())  left[k] <= CYC_K[k] - 1;
                mcnt[k][0] <= bump(k, mcnt[k][0], (left[k] == 0) && m_lu());
                mcnt[k][1] <= bump(k, mcnt[k][1], (left[k] == 0) && m_bd() && !m_lu());
                mcnt[k][2] <= bump(k, mcnt[k][2], m_flush(k));
                mcnt[k][3] <= bump(k, mcnt[k][3], m_stall(k));
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model_outs_dut%0d", k), 64'(got_o[k]), 64'(m_outs(k)));
            for (int j = 0; j < 4; j++)
                chk($sformatf("model_cnt%0d_dut%0d", j, k), got_c[k][j], 64'(mcnt[k][j]));
        end
    endtask

    task automatic neg();
        @(negedge clk);
        check_model();
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_id = 0; uses_rt_id = 0; memread_ex = 0; regwrite_ex = 0; memread_mem = 0;
        branch_id = 0; jump_id = 0; branch_taken = 0; stat_clr = 0;
        rs_id = 0; rt_id = 0; rd_ex = 0; rd_mem = 0;
    endtask

    task automatic load_stim();
        idle();
        valid_id = 1; memread_ex = 1; rd_ex = 5'd8; rs_id = 5'd8;
    endtask

    task automatic clear_stats();
        idle();
        stat_clr = 1;
        neg();
        pos();
        stat_clr = 0;
    endtask

    typedef struct {
        logic       valid, uses_rt, mr_ex, rw_ex, mr_mem, br, jmp, tkn;
        logic [4:0] rs, rt, rdx, rdm;
        logic       e_stall, e_flush;
        logic [1:0] e_status;
    } vec_t;

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
        input logic mr, input logic rw, input logic [4:0] rdx,
        input logic mm, input logic [4:0] rdm,
        input logic br, input logic j, input logic tk,
        input logic es, input logic ef, input logic [1:0] est);
        vec_t r;
        r.valid = v; r.rs = rs; r.rt = rt; r.uses_rt = urt;
        r.mr_ex = mr; r.rw_ex = rw; r.rdx = rdx; r.mr_mem = mm; r.rdm = rdm;
        r.br = br; r.jmp = j; r.tkn = tk;
        r.e_stall = es; r.e_flush = ef; r.e_status = est;
        return r;
    endfunction

    vec_t tbl [16];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // valid rs rt urt | mr rw rdx | mm rdm | br j tk | stall flush status
        tbl[0]  = mk(1, 1, 2, 1,  0, 0, 3,  0, 0,  0, 0, 0,  0, 0, 2'd0);
        tbl[1]  = mk(1, 8, 0, 0,  1, 0, 8,  0, 0,  0, 0, 0,  1, 0, 2'd1);
        tbl[2]  = mk(1, 2, 6, 1,  1, 0, 6,  0, 0,  0, 0, 0,  1, 0, 2'd1);
        tbl[3]  = mk(1, 3, 9, 0,  1, 0, 9,  0, 0,  0, 0, 0,  0, 0, 2'd0);
        tbl[4]  = mk(1, 0, 0, 1,  1, 0, 0,  0, 0,  0, 0, 0,  0, 0, 2'd0);
        tbl[5]  = mk(0, 8, 0, 0,  1, 0, 8,  0, 0,  0, 0, 0,  0, 0, 2'd0);
        tbl[6]  = mk(1, 1, 4, 1,  0, 1, 4,  0, 0,  1, 0, 1,  1, 0, 2'd2);
        tbl[7]  = mk(1, 5, 0, 0,  0, 0, 0,  1, 5,  1, 0, 0,  1, 0, 2'd2);
        tbl[8]  = mk(1, 4, 0, 0,  0, 1, 4,  0, 0,  0, 0, 0,  0, 0, 2'd0);
        tbl[9]  = mk(1, 1, 2, 1,  0, 0, 0,  0, 0,  0, 1, 0,  0, 1, 2'd3);
        tbl[10] = mk(1, 1, 2, 1,  0, 1, 3,  0, 0,  1, 0, 1,  0, 1, 2'd3);
        tbl[11] = mk(1, 1, 2, 1,  0, 1, 3,  0, 0,  1, 0, 0,  0, 0, 2'd0);
        tbl[12] = mk(1, 7, 0, 0,  1, 1, 7,  0, 0,  1, 0, 1,  1, 0, 2'd1);
        tbl[13] = mk(1, 3, 0, 0,  1, 0, 3,  0, 0,  0, 1, 0,  1, 0, 2'd1);
        tbl[14] = mk(1, 5, 0, 0,  0, 0, 0,  1, 5,  0, 0, 0,  0, 0, 2'd0);
        tbl[15] = mk(1, 0, 0, 0,  0, 0, 0,  1, 0,  1, 0, 1,  0, 1, 2'd3);

        // Reset, with a load hazard presented to prove outputs stay gated.
        rst_n = 0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        load_stim();
        neg();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_outs_dut%0d", k), 64'(got_o[k]), 64'd0);
            chk($sformatf("reset_load_cnt_dut%0d", k), got_c[k][0], 64'd0);
        end
        $display("reset: outs a/b/c = %b %b %b", got_o[0], got_o[1], got_o[2]);
        pos();
        rst_n = 1;
        idle();
        neg();
        pos();

        // Single-cycle decode table on the one-bubble instance.
        for (int i = 0; i < 16; i++) begin
            valid_id = tbl[i].valid; rs_id = tbl[i].rs; rt_id = tbl[i].rt;
            uses_rt_id = tbl[i].uses_rt; memread_ex = tbl[i].mr_ex; regwrite_ex = tbl[i].rw_ex;
            rd_ex = tbl[i].rdx; memread_mem = tbl[i].mr_mem; rd_mem = tbl[i].rdm;
            branch_id = tbl[i].br; jump_id = tbl[i].jmp; branch_taken = tbl[i].tkn;
            neg();
            chk($sformatf("tbl%0d_outs", i), 64'(got_o[0]),
                64'({tbl[i].e_stall, tbl[i].e_stall, tbl[i].e_stall, tbl[i].e_flush, tbl[i].e_status}));
            $display("vec %0d: stall=%b flush=%b status=%0d", i, got_o[0][5], got_o[0][2], got_o[0][1:0]);
            pos();
        end
        idle();
        repeat (3) begin neg(); pos(); end

        // One-cycle load hazard: A stalls once, B keeps stalling for three cycles.
        clear_stats();
        load_stim();
        neg();
        chk("ld1_a_outs", 64'(got_o[0]), 64'b111001);
        chk("ld1_b_outs", 64'(got_o[1]), 64'b111001);
        pos();
        idle();
        neg();
        chk("ld1_a_clear", 64'(got_o[0]), 64'd0);
        chk("ld1_a_load_cnt", got_c[0][0], 64'd1);
        chk("ld1_a_stall_cnt", got_c[0][3], 64'd1);
        chk("ld1_b_cyc2", 64'(got_o[1]), 64'b111001);
        pos();
        neg();
        chk("ld1_b_cyc3", 64'(got_o[1]), 64'b111001);
        pos();
        neg();
        chk("ld1_b_done", 64'(got_o[1]), 64'd0);
        $display("load seq: a load=%0d stall=%0d b stall=%0d", got_c[0][0], got_c[0][3], got_c[1][3]);
        pos();

        // Three-bubble load with the hazard held for the whole stall.
        clear_stats();
        load_stim();
        for (int i = 0; i < 3; i++) begin
            neg();
            chk($sformatf("ld3_b_cyc%0d", i + 1), 64'(got_o[1]), 64'b111001);
            pos();
        end
        idle();
        neg();
        chk("ld3_b_done", 64'(got_o[1]), 64'd0);
        chk("ld3_b_load_cnt", got_c[1][0], 64'd1);
        chk("ld3_b_stall_cnt", got_c[1][3], 64'd3);
        $display("held load seq: b load=%0d stall=%0d", got_c[1][0], got_c[1][3]);
        pos();

        // Branch dependency, then deferred control flush once it clears.
        clear_stats();
        valid_id = 1; branch_id = 1; branch_taken = 1; regwrite_ex = 1;
        rd_ex = 5'd4; rt_id = 5'd4; uses_rt_id = 1; rs_id = 5'd1;
        neg();
        chk("br_cyc1_a", 64'(got_o[0]), 64'b111010);
        pos();
        regwrite_ex = 0;
        neg();
        chk("br_cyc2_a", 64'(got_o[0]), 64'b000111);
        pos();
        idle();
        neg();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("br_control_cnt_dut%0d", k), got_c[k][2], 64'd1);
            chk($sformatf("br_branch_cnt_dut%0d", k), got_c[k][1], 64'd1);
        end
        $display("branch seq: control=%0d branch=%0d", got_c[0][2], got_c[0][1]);
        pos();

        // Nine load events against the 3-bit counters, then clear with an event.
        clear_stats();
        repeat (9) begin
            load_stim();
            neg();
            pos();
            idle();
            neg();
            pos();
        end
        neg();
        chk("sat_c_load_cnt", got_c[2][0], 64'd7);
        chk("sat_c_stall_cnt", got_c[2][3], 64'd7);
        chk("sat_a_load_cnt", got_c[0][0], 64'd9);
        pos();
        load_stim();
        stat_clr = 1;
        neg();
        pos();
        idle();
        neg();
        chk("clr_c_load_cnt", got_c[2][0], 64'd0);
        $display("saturation seq: c load after clear=%0d", got_c[2][0]);
        pos();
        repeat (2) begin neg(); pos(); end

        // Reset during the second cycle of a three-bubble stall.
        load_stim();
        neg();
        pos();
        idle();
        rst_n = 0;
        neg();
        chk("rst_mid_b_outs", 64'(got_o[1]), 64'd0);
        pos();
        rst_n = 1;
        neg();
        chk("rst_after_b_outs", 64'(got_o[1]), 64'd0);
        chk("rst_after_b_load_cnt", got_c[1][0], 64'd0);
        pos();
        neg();
        chk("rst_after2_b_outs", 64'(got_o[1]), 64'd0);
        $display("reset-mid-stall seq: b outs=%b", got_o[1]);
        pos();

        // Randomised traffic against the model on all three instances.
        for (int n = 0; n < 500; n++) begin
            valid_id     = ($urandom_range(0, 7) != 0);
            rs_id        = 5'($urandom_range(0, 3));
            rt_id        = 5'($urandom_range(0, 3));
            rd_ex        = 5'($urandom_range(0, 3));
            rd_mem       = 5'($urandom_range(0, 3));
            uses_rt_id   = 1'($urandom_range(0, 1));
            memread_ex   = ($urandom_range(0, 2) == 0);
            regwrite_ex  = 1'($urandom_range(0, 1));
            memread_mem  = 1'($urandom_range(0, 1));
            branch_id    = ($urandom_range(0, 2) == 0);
            jump_id      = ($urandom_range(0, 5) == 0);
            branch_taken = 1'($urandom_range(0, 1));
            stat_clr     = ($urandom_range(0, 15) == 0);
            rst_n        = ($urandom_range(0, 39) != 0);
            neg();
            $display("rand %0d: rst_n=%b outs a/b/c = %b %b %b", n, rst_n, got_o[0], got_o[1], got_o[2]);
            pos();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
